// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath.
// Phase width, degree constants and tracker state encoding.
package cordic_pkg;

   localparam int PHASE_W = 32;
   localparam int DEG_180 = 180;
   localparam int DEG_360 = 360;

   typedef enum logic [1:0] {
      IDLE  = 2'b01,
      TRACK = 2'b10
   } track_state_t;

endpackage

// File: rtl/cordic_phase_track_if.sv
// Sample bus from the CORDIC vectoring stage.
// Master drives the strobe and payload, slave consumes it.
interface cordic_phase_track_if;
   import cordic_pkg::*;

   logic                      in_valid;
   logic signed [PHASE_W-1:0] phase;
   logic        [31:0]        value;

   modport master (
      output in_valid,
      output phase,
      output value
   );

   modport slave (
      input in_valid,
      input phase,
      input value
   );

endinterface

// File: rtl/phase_wrap_diff.sv
// Phase step between two samples, folded into [-180,180].
// Exactly +/-180 are left unchanged.
module phase_wrap_diff
   import cordic_pkg::*;
(
   input  logic signed [PHASE_W-1:0] phase,
   input  logic signed [PHASE_W-1:0] prev_phase,
   output logic signed [PHASE_W-1:0] d
);

   localparam logic signed [PHASE_W-1:0] POS_HALF = DEG_180;
   localparam logic signed [PHASE_W-1:0] NEG_HALF = -DEG_180;
   localparam logic signed [PHASE_W-1:0] FULL     = DEG_360;

   logic signed [PHASE_W-1:0] raw;

   // single wrap correction of the raw difference
   always_comb begin
      raw = phase - prev_phase;
      d   = raw;
      if (raw > POS_HALF) begin
         d = raw - FULL;
      end else if (raw < NEG_HALF) begin
         d = raw + FULL;
      end
   end

endmodule

// File: rtl/cordic_phase_track.sv
// Phase unwrapper and block-averaged frequency estimator.
// Low-magnitude samples are dropped and break the track.
module cordic_phase_track
   import cordic_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 3,
   parameter logic [31:0] MAG_MIN  = 32'd16
) (
   input  logic                clk,
   input  logic                rst_n,
   cordic_phase_track_if.slave cin,
   input  logic                clear,
   output logic                lock,
   output logic                unwrap_valid,
   output logic [31:0]         unwrap_phase,
   output logic                freq_valid,
   output logic [31:0]         freq_avg,
   output logic [15:0]         drop_cnt
);

   localparam logic [8:0] N_CNT = 9'(1 << AVG_LOG2);

   track_state_t              state;
   logic signed [PHASE_W-1:0] prev_phase;
   logic signed [PHASE_W-1:0] acc;
   logic        [8:0]         cnt;
   logic signed [PHASE_W-1:0] d;
   logic signed [PHASE_W-1:0] acc_sum;
   logic        [8:0]         cnt_inc;
   logic                      accept;
   logic                      reject;

   phase_wrap_diff u_wrap (
      .phase      (cin.phase),
      .prev_phase (prev_phase),
      .d          (d)
   );

   // next accumulator values and sample classification
   always_comb begin
      acc_sum = acc + d;
      cnt_inc = cnt + 9'd1;
      accept  = cin.in_valid && !clear && (cin.value >= MAG_MIN);
      reject  = cin.in_valid && !clear && (cin.value < MAG_MIN);
   end

   // tracking FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lock         <= 1'b0;
         prev_phase   <= '0;
         acc          <= '0;
         cnt          <= '0;
         unwrap_valid <= 1'b0;
         unwrap_phase <= '0;
         freq_valid   <= 1'b0;
         freq_avg     <= '0;
         drop_cnt     <= '0;
      end else begin
         unwrap_valid <= 1'b0;
         freq_valid   <= 1'b0;
         if (clear || reject) begin
            state <= IDLE;
            lock  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            if (reject && drop_cnt != 16'hFFFF) begin
               drop_cnt <= drop_cnt + 16'd1;
            end
         end else if (accept) begin
            prev_phase   <= cin.phase;
            unwrap_valid <= 1'b1;
            unique case (1'b1)
               (state == IDLE): begin
                  state        <= TRACK;
                  lock         <= 1'b1;
                  unwrap_phase <= cin.phase;
               end
               (state == TRACK): begin
                  unwrap_phase <= unwrap_phase + d;
                  if (cnt_inc == N_CNT) begin
                     freq_avg   <= acc_sum >>> AVG_LOG2;
                     freq_valid <= 1'b1;
                     acc        <= '0;
                     cnt        <= '0;
                  end else begin
                     acc <= acc_sum;
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  state <= IDLE;
                  lock  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cordic_phase_track.sv
// Bench for cordic_phase_track and phase_wrap_diff.
// Directed and random samples against a queue-based model.
module tb_cordic_phase_track;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        lock;
   logic        unwrap_valid;
   logic [31:0] unwrap_phase;
   logic        freq_valid;
   logic [31:0] freq_avg;
   logic [15:0] drop_cnt;

   logic signed [31:0] wp;
   logic signed [31:0] wq;
   logic signed [31:0] wd;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit          m_lock;
   int          m_prev;
   int          m_unwrap;
   int          m_freq;
   int          m_drop;
   int          m_diffs[$];
   bit          e_uv;
   bit          e_fv;

   always #5 clk = ~clk;

   cordic_phase_track_if bus();

   cordic_phase_track #(
      .AVG_LOG2 (3),
      .MAG_MIN  (32'd16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cin          (bus),
      .clear        (clear),
      .lock         (lock),
      .unwrap_valid (unwrap_valid),
      .unwrap_phase (unwrap_phase),
      .freq_valid   (freq_valid),
      .freq_avg     (freq_avg),
      .drop_cnt     (drop_cnt)
   );

   phase_wrap_diff u_wrap (
      .phase      (wp),
      .prev_phase (wq),
      .d          (wd)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs),
                $signed(exp));
      end
   endtask

   function automatic int wrapd(int a, int b);
      int d;
      d = a - b;
      if (d > 180) d = d - 360;
      else if (d < -180) d = d + 360;
      return d;
   endfunction

   function automatic int floordiv(int s, int n);
      int q;
      q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_lock = 0;
      m_prev = 0;
      m_unwrap = 0;
      m_freq = 0;
      m_drop = 0;
      m_diffs.delete();
   endtask

   task automatic model_step(input bit v, input int p, input int unsigned val,
                             input bit clr);
      int d;
      int s;
      e_uv = 0;
      e_fv = 0;
      if (clr) begin
         m_lock = 0;
         m_diffs.delete();
      end else if (v) begin
         if (val < 16) begin
            if (m_drop != 65535) m_drop++;
            m_lock = 0;
            m_diffs.delete();
         end else if (!m_lock) begin
            m_lock = 1;
            m_prev = p;
            m_unwrap = p;
            e_uv = 1;
         end else begin
            d = wrapd(p, m_prev);
            m_unwrap = m_unwrap + d;
            m_prev = p;
            m_diffs.push_back(d);
            e_uv = 1;
            if (m_diffs.size() == 8) begin
               s = 0;
               foreach (m_diffs[i]) s += m_diffs[i];
               m_freq = floordiv(s, 8);
               e_fv = 1;
               m_diffs.delete();
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".lock"}, 32'(lock), 32'(m_lock));
      chk({tag, ".uv"}, 32'(unwrap_valid), 32'(e_uv));
      chk({tag, ".up"}, unwrap_phase, m_unwrap);
      chk({tag, ".fv"}, 32'(freq_valid), 32'(e_fv));
      chk({tag, ".fa"}, freq_avg, m_freq);
      chk({tag, ".drop"}, 32'(drop_cnt), m_drop);
   endtask

   task automatic step(input string tag, input bit v, input int p,
                       input int unsigned val, input bit clr);
      @(negedge clk);
      bus.in_valid = v;
      bus.phase = p;
      bus.value = val;
      clear = clr;
      model_step(v, p, val, clr);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic wrap_vec(input int a, input int b, input int exp);
      wp = a;
      wq = b;
      #1;
      chk("wrap", wd, exp);
   endtask

   initial begin
      int rp;
      int unsigned rv;
      bit rvld;
      bit rclr;

      bus.in_valid = 0;
      bus.phase = 0;
      bus.value = 0;
      wp = 0;
      wq = 0;
      model_reset();

      wrap_vec(180, 0, 180);
      wrap_vec(0, 180, -180);
      wrap_vec(-150, 180, 30);
      wrap_vec(150, -150, -60);
      wrap_vec(10, 20, -10);
      wrap_vec(-180, 180, 0);

      #12;
      e_uv = 0;
      e_fv = 0;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1;

      step("seed10", 1, 10, 100, 0);
      chk("seed10.lit", unwrap_phase, 10);
      step("p20", 1, 20, 100, 0);
      step("p30", 1, 30, 100, 0);
      chk("p30.lit", unwrap_phase, 30);

      step("clr", 0, 0, 0, 1);
      step("r150", 1, 150, 100, 0);
      step("r180", 1, 180, 100, 0);
      step("rm150", 1, -150, 100, 0);
      chk("rm150.lit", unwrap_phase, 210);
      step("rm120", 1, -120, 100, 0);
      chk("rm120.lit", unwrap_phase, 240);

      step("clr", 0, 0, 0, 1);
      step("h0", 1, 0, 100, 0);
      step("h180", 1, 180, 100, 0);
      chk("h180.lit", unwrap_phase, 180);
      step("h0b", 1, 0, 100, 0);
      chk("h0b.lit", unwrap_phase, 0);

      step("clr", 0, 0, 0, 1);
      for (int k = 0; k <= 8; k++) step("ramp", 1, k * 10, 100, 0);
      chk("ramp.fv.lit", 32'(freq_valid), 1);
      chk("ramp.fa.lit", freq_avg, 10);
      step("idle", 0, 0, 0, 0);

      step("clr", 0, 0, 0, 1);
      for (int k = 0; k <= 7; k++) step("neg", 1, -2 * k, 100, 0);
      step("neg17", 1, -17, 100, 0);
      chk("neg.fa.lit", freq_avg, -3);

      step("t0", 1, 40, 100, 0);
      step("drop", 1, 50, 5, 0);
      chk("drop.lit", 32'(drop_cnt), 1);
      step("reseed", 1, 90, 100, 0);
      chk("reseed.lit", unwrap_phase, 90);
      step("clrv", 1, 120, 5, 1);
      chk("clrv.lit", 32'(drop_cnt), 1);
      step("clrv2", 1, 120, 100, 1);
      step("edge16", 1, 100, 16, 0);
      step("edge15", 1, 110, 15, 0);

      step("pre", 1, 5, 100, 0);
      step("pre2", 1, 15, 100, 0);
      @(negedge clk);
      bus.in_valid = 0;
      #2;
      rst_n = 0;
      #1;
      model_reset();
      e_uv = 0;
      e_fv = 0;
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1;
      step("post", 1, -60, 100, 0);

      for (int i = 0; i < 300; i++) begin
         rvld = ($urandom_range(3) != 0);
         rclr = ($urandom_range(29) == 0);
         rp = int'($urandom_range(360)) - 180;
         rv = ($urandom_range(15) == 0) ? $urandom_range(15)
                                         : $urandom_range(5000, 16);
         step("rand", rvld, rp, rv, rclr);
      end
      step("idle", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
